// File: rtl/ujtag_chain_arb_pkg.sv
// ============================================================================
// ujtag_chain_arb_pkg : shared types and constants for the UJTAG chain arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package ujtag_chain_arb_pkg;

    localparam int C_NUM_CLIENTS = 4;
    localparam int C_SCAN_LEN_W  = 16;
    localparam int C_ABORT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_UPDATE  = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/ujtag_arb_bypass.sv
// ============================================================================
// ujtag_arb_bypass : one-bit bypass register used when no client owns the scan
// Rev 1.0
// ============================================================================
`default_nettype none

module ujtag_arb_bypass (
    input  logic clk,
    input  logic rst_n,
    input  logic i_capture,
    input  logic i_shift,
    input  logic i_tdi,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (i_capture) begin
            r_q <= 1'b0;
        end else if (i_shift) begin
            r_q <= i_tdi;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/ujtag_chain_arb.sv
// ============================================================================
// ujtag_chain_arb : routes UJTAG user-register scans to one of four clients
// Rev 1.0
// ============================================================================
`default_nettype none

module ujtag_chain_arb
    import ujtag_chain_arb_pkg::*;
#(
    parameter logic [7:0] IR_CODE_0 = 8'h56,
    parameter logic [7:0] IR_CODE_1 = 8'h57,
    parameter logic [7:0] IR_CODE_2 = 8'h58,
    parameter logic [7:0] IR_CODE_3 = 8'h59
) (
    input  logic                     UDRCK,
    input  logic                     URSTB,
    input  logic [7:0]               UIREG_IN,
    input  logic                     UDRCAP_IN,
    input  logic                     UDRSH_IN,
    input  logic                     UDRUPD_IN,
    input  logic                     UTDI_IN,
    input  logic [C_NUM_CLIENTS-1:0] UTDO_IN,
    output logic [C_NUM_CLIENTS-1:0] UDRCAP_OUT,
    output logic [C_NUM_CLIENTS-1:0] UDRSH_OUT,
    output logic [C_NUM_CLIENTS-1:0] UDRUPD_OUT,
    output logic                     UTDO_OUT,
    output logic                     UTDODRV_OUT,
    output logic [C_NUM_CLIENTS-1:0] GRANT,
    output logic [C_SCAN_LEN_W-1:0]  SCAN_LEN,
    output logic [C_ABORT_CNT_W-1:0] ABORT_CNT
);

    arb_state_t                 r_state, w_state_nxt;
    logic [C_NUM_CLIENTS-1:0]   r_grant, w_grant_nxt;
    logic [7:0]                 r_ir_q, w_ir_nxt;
    logic [C_SCAN_LEN_W-1:0]    r_shift_cnt, w_cnt_nxt, w_cnt_inc, w_cnt_cur;
    logic [C_SCAN_LEN_W-1:0]    r_scan_len, w_len_nxt;
    logic [C_ABORT_CNT_W-1:0]   r_abort_cnt, w_abort_nxt;
    logic [C_NUM_CLIENTS-1:0]   r_cap_out, r_sh_out, r_upd_out;
    logic [C_NUM_CLIENTS-1:0]   w_cap_nxt, w_sh_nxt, w_upd_nxt;
    logic [C_NUM_CLIENTS-1:0]   w_match, w_sel;
    logic                       w_abort;
    logic                       w_bypass_q;

    assign w_match = {UIREG_IN == IR_CODE_3, UIREG_IN == IR_CODE_2,
                      UIREG_IN == IR_CODE_1, UIREG_IN == IR_CODE_0};

    // Walk from the top so the lowest matching index is the last one written.
    always_comb begin
        w_sel = '0;
        for (int i = C_NUM_CLIENTS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_sel    = '0;
                w_sel[i] = 1'b1;
            end
        end
    end

    assign w_cnt_inc = (&r_shift_cnt) ? r_shift_cnt : r_shift_cnt + 1'b1;

    // A changed instruction, or a capture arriving mid-shift, kills the scan.
    assign w_abort = (r_state != ST_IDLE) &&
                     ((UIREG_IN != r_ir_q) || ((r_state == ST_SHIFT) && UDRCAP_IN));

    always_ff @(posedge UDRCK) begin
        if (!URSTB) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_ir_q      <= '0;
            r_shift_cnt <= '0;
            r_scan_len  <= '0;
            r_abort_cnt <= '0;
            r_cap_out   <= '0;
            r_sh_out    <= '0;
            r_upd_out   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_ir_q      <= w_ir_nxt;
            r_shift_cnt <= w_cnt_nxt;
            r_scan_len  <= w_len_nxt;
            r_abort_cnt <= w_abort_nxt;
            r_cap_out   <= w_cap_nxt;
            r_sh_out    <= w_sh_nxt;
            r_upd_out   <= w_upd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ir_nxt    = r_ir_q;
        w_cnt_nxt   = r_shift_cnt;
        w_len_nxt   = r_scan_len;
        w_abort_nxt = r_abort_cnt;
        w_cnt_cur   = UDRSH_IN ? w_cnt_inc : r_shift_cnt;
        w_cap_nxt   = ((r_state == ST_IDLE) && UDRCAP_IN) ? w_sel : '0;
        w_sh_nxt    = UDRSH_IN ? r_grant : '0;
        w_upd_nxt   = (UDRUPD_IN && !w_abort) ? r_grant : '0;

        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_cnt_nxt   = '0;
            w_abort_nxt = (&r_abort_cnt) ? r_abort_cnt : r_abort_cnt + 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (UDRCAP_IN && (|w_match)) begin
                        w_state_nxt = ST_CAPTURE;
                        w_grant_nxt = w_sel;
                        w_ir_nxt    = UIREG_IN;
                        w_cnt_nxt   = '0;
                    end
                end
                // The shift bit of the current cycle is counted before any update load.
                ST_CAPTURE, ST_SHIFT: begin
                    if (UDRUPD_IN) begin
                        w_state_nxt = ST_UPDATE;
                        w_len_nxt   = w_cnt_cur;
                        w_cnt_nxt   = '0;
                    end else if (UDRSH_IN) begin
                        w_state_nxt = ST_SHIFT;
                        w_cnt_nxt   = w_cnt_cur;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                end
            endcase
        end
    end

    ujtag_arb_bypass u_bypass (
        .clk       (UDRCK),
        .rst_n     (URSTB),
        .i_capture (UDRCAP_IN),
        .i_shift   (UDRSH_IN),
        .i_tdi     (UTDI_IN),
        .o_q       (w_bypass_q)
    );

    assign UTDO_OUT    = (|r_grant) ? (|(UTDO_IN & r_grant)) : w_bypass_q;
    assign UTDODRV_OUT = (r_state != ST_IDLE);
    assign GRANT       = r_grant;
    assign SCAN_LEN    = r_scan_len;
    assign ABORT_CNT   = r_abort_cnt;
    assign UDRCAP_OUT  = r_cap_out;
    assign UDRSH_OUT   = r_sh_out;
    assign UDRUPD_OUT  = r_upd_out;

endmodule

`default_nettype wire

// File: tb/tb_ujtag_chain_arb.sv
// ============================================================================
// tb_ujtag_chain_arb : table, directed and randomized checks of ujtag_chain_arb
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ujtag_chain_arb;

    logic       clk = 1'b0;
    logic       rstb, cap, sh, upd, tdi;
    logic [7:0] ireg;
    logic [3:0] tdo_in;
    logic [3:0] cap_out, sh_out, upd_out, grant;
    logic       tdo_out, drv;
    logic [15:0] scan_len;
    logic [7:0]  abort_cnt;
    logic [3:0] cap_out2, sh_out2, upd_out2, grant2;
    logic       tdo_out2, drv2;
    logic [15:0] scan_len2;
    logic [7:0]  abort_cnt2;

    always #5 clk = ~clk;

    ujtag_chain_arb dut (
        .UDRCK(clk), .URSTB(rstb), .UIREG_IN(ireg), .UDRCAP_IN(cap), .UDRSH_IN(sh),
        .UDRUPD_IN(upd), .UTDI_IN(tdi), .UTDO_IN(tdo_in), .UDRCAP_OUT(cap_out),
        .UDRSH_OUT(sh_out), .UDRUPD_OUT(upd_out), .UTDO_OUT(tdo_out), .UTDODRV_OUT(drv),
        .GRANT(grant), .SCAN_LEN(scan_len), .ABORT_CNT(abort_cnt)
    );

    ujtag_chain_arb #(.IR_CODE_0(8'h56), .IR_CODE_2(8'h56)) dut2 (
        .UDRCK(clk), .URSTB(rstb), .UIREG_IN(ireg), .UDRCAP_IN(cap), .UDRSH_IN(sh),
        .UDRUPD_IN(upd), .UTDI_IN(tdi), .UTDO_IN(tdo_in), .UDRCAP_OUT(cap_out2),
        .UDRSH_OUT(sh_out2), .UDRUPD_OUT(upd_out2), .UTDO_OUT(tdo_out2), .UTDODRV_OUT(drv2),
        .GRANT(grant2), .SCAN_LEN(scan_len2), .ABORT_CNT(abort_cnt2)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: scan phase 0 idle, 1 captured, 2 shifting, 3 updating.
    logic [7:0] codes [4] = '{8'h56, 8'h57, 8'h58, 8'h59};
    int         m_phase = 0, m_owner = -1, m_cnt = 0, m_len = 0, m_abort = 0;
    logic [7:0] m_ir = 8'h00;
    bit         m_byp = 1'b0;
    logic [3:0] e_cap = 4'h0, e_sh = 4'h0, e_upd = 4'h0;
    bit         e_tdo, pre_tdo, pre_tdo2;

    function automatic logic [3:0] onehot(input int idx);
        logic [3:0] v;
        v = 4'h0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  sel;
        bit  ab;
        e_tdo = (m_owner >= 0) ? tdo_in[m_owner] : m_byp;
        if (!rstb) begin
            m_phase = 0; m_owner = -1; m_ir = 8'h00; m_cnt = 0; m_len = 0; m_abort = 0;
            m_byp = 1'b0; e_cap = 4'h0; e_sh = 4'h0; e_upd = 4'h0;
            return;
        end
        e_cap = 4'h0;
        e_sh  = sh  ? onehot(m_owner) : 4'h0;
        e_upd = upd ? onehot(m_owner) : 4'h0;
        ab = (m_phase != 0) && ((ireg != m_ir) || (m_phase == 2 && cap));
        if (ab) begin
            e_upd = 4'h0; m_phase = 0; m_owner = -1; m_cnt = 0;
            if (m_abort < 255) m_abort++;
        end else if (m_phase == 0) begin
            if (cap) begin
                sel = -1;
                for (int i = 3; i >= 0; i--) if (ireg == codes[i]) sel = i;
                if (sel >= 0) begin
                    m_owner = sel; m_phase = 1; m_ir = ireg; m_cnt = 0; e_cap = onehot(sel);
                end
            end
        end else if (m_phase == 3) begin
            m_phase = 0; m_owner = -1;
        end else begin
            if (sh) m_cnt++;
            if (upd) begin
                m_len = (m_cnt > 65535) ? 65535 : m_cnt; m_cnt = 0; m_phase = 3;
            end else if (sh) begin
                m_phase = 2;
            end
        end
        if (cap) m_byp = 1'b0;
        else if (sh) m_byp = tdi;
    endtask

    // One UDRCK cycle: drive, sample the combinational TDO, clock, compare.
    task automatic cyc(input bit r, input bit c, input bit s, input bit u, input bit t,
                       input logic [7:0] ir, input logic [3:0] ti);
        rstb = r; cap = c; sh = s; upd = u; tdi = t; ireg = ir; tdo_in = ti;
        #1;
        pre_tdo  = tdo_out;
        pre_tdo2 = tdo_out2;
        model_step();
        chk("utdo", 32'(pre_tdo), 32'(e_tdo));
        @(posedge clk);
        #1;
        chk("grant",     32'(grant),     32'(onehot(m_owner)));
        chk("cap_out",   32'(cap_out),   32'(e_cap));
        chk("sh_out",    32'(sh_out),    32'(e_sh));
        chk("upd_out",   32'(upd_out),   32'(e_upd));
        chk("drv",       32'(drv),       32'(m_phase != 0));
        chk("scan_len",  32'(scan_len),  32'(m_len));
        chk("abort_cnt", 32'(abort_cnt), 32'(m_abort));
    endtask

    typedef struct {
        bit         rn, c, s, u, t;
        logic [7:0] ir;
        logic [3:0] ti;
        logic [3:0] g, co, so, uo;
        logic [15:0] len;
        bit         dv, td;
    } vec_t;

    vec_t       tbl [8];
    int         cnt_sh, cnt_upd;
    logic [4:0] got;
    logic [4:0] pat;
    logic [15:0] len_before;
    logic [7:0] cur_ir;
    logic [7:0] ir_pool [6] = '{8'h56, 8'h57, 8'h58, 8'h59, 8'h20, 8'h5A};

    initial begin
        tbl[0] = '{1, 1, 0, 0, 0, 8'h57, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 16'd0, 1, 0};
        tbl[1] = '{1, 0, 1, 0, 1, 8'h57, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 16'd0, 1, 1};
        tbl[2] = '{1, 0, 1, 0, 0, 8'h57, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 16'd0, 1, 0};
        tbl[3] = '{1, 0, 1, 1, 1, 8'h57, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 16'd3, 1, 1};
        tbl[4] = '{1, 0, 0, 0, 0, 8'h57, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd3, 0, 0};
        tbl[5] = '{1, 1, 0, 0, 0, 8'h20, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd3, 0, 1};
        tbl[6] = '{1, 0, 1, 0, 1, 8'h20, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd3, 0, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 8'h20, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd0, 0, 1};

        cyc(0, 0, 0, 0, 0, 8'h00, 4'h0);
        cyc(0, 0, 0, 0, 0, 8'h00, 4'h0);
        chk("rst2_grant", 32'(grant2), 32'h0);

        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].rn, tbl[i].c, tbl[i].s, tbl[i].u, tbl[i].t, tbl[i].ir, tbl[i].ti);
            chk("tbl_tdo",   32'(pre_tdo),   32'(tbl[i].td));
            chk("tbl_grant", 32'(grant),     32'(tbl[i].g));
            chk("tbl_cap",   32'(cap_out),   32'(tbl[i].co));
            chk("tbl_sh",    32'(sh_out),    32'(tbl[i].so));
            chk("tbl_upd",   32'(upd_out),   32'(tbl[i].uo));
            chk("tbl_len",   32'(scan_len),  32'(tbl[i].len));
            chk("tbl_drv",   32'(drv),       32'(tbl[i].dv));
            chk("tbl_abort", 32'(abort_cnt), 32'h0);
        end
        chk("tbl_rst_d2", 32'({grant2, cap_out2, sh_out2, upd_out2, drv2, abort_cnt2}), 32'h0);
        chk("tbl_rst_d2len", 32'(scan_len2), 32'h0);
        chk("tbl_rst_d2tdo", 32'(pre_tdo2), 32'h1);

        // Client 1, 12-bit scan
        cyc(1, 1, 0, 0, 0, 8'h57, 4'h0);
        cnt_sh = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, 1, 0, 1'($urandom), 8'h57, 4'($urandom));
            cnt_sh += int'(sh_out[1]);
            chk("s1_grant", 32'(grant), 32'b0010);
        end
        cyc(1, 0, 0, 1, 0, 8'h57, 4'h0);
        cnt_upd = int'(upd_out[1]);
        chk("s1_len", 32'(scan_len), 32'd12);
        cyc(1, 0, 0, 0, 0, 8'h57, 4'h0);
        cnt_upd += int'(upd_out[1]);
        chk("s1_sh_pulses", 32'(cnt_sh), 32'd12);
        chk("s1_upd_pulses", 32'(cnt_upd), 32'd1);

        // Unmatched IR goes through the bypass bit
        cyc(1, 1, 0, 0, 0, 8'h20, 4'hF);
        pat = 5'b10110;
        got = 5'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 1, 0, pat[4-i], 8'h20, 4'hF);
            got = {got[3:0], pre_tdo};
            chk("s2_grant", 32'(grant), 32'h0);
            chk("s2_drv", 32'(drv), 32'h0);
        end
        chk("s2_bypass_seq", 32'(got), 32'b01011);

        // Duplicate IR codes: lowest index wins
        cyc(1, 1, 0, 0, 0, 8'h56, 4'h0);
        chk("s3_grant2", 32'(grant2), 32'b0001);
        chk("s3_cap2", 32'(cap_out2), 32'b0001);
        cyc(1, 0, 0, 1, 0, 8'h56, 4'h0);
        cyc(1, 0, 0, 0, 0, 8'h56, 4'h0);

        // IR change mid-scan aborts, even with a coincident update strobe
        cyc(0, 0, 0, 0, 0, 8'h00, 4'h0);
        cyc(1, 1, 0, 0, 0, 8'h58, 4'h0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 8'h58, 4'h0);
        len_before = scan_len;
        cyc(1, 0, 1, 1, 0, 8'h59, 4'h0);
        chk("s4_abort", 32'(abort_cnt), 32'd1);
        chk("s4_grant", 32'(grant), 32'h0);
        chk("s4_upd", 32'(upd_out), 32'h0);
        cyc(1, 0, 0, 1, 0, 8'h59, 4'h0);
        chk("s4_upd_after", 32'(upd_out), 32'h0);
        chk("s4_len", 32'(scan_len), 32'(len_before));
        // Capture during shift aborts and does not restart
        cyc(1, 1, 0, 0, 0, 8'h59, 4'h0);
        cyc(1, 0, 1, 0, 0, 8'h59, 4'h0);
        cyc(1, 0, 1, 0, 0, 8'h59, 4'h0);
        cyc(1, 1, 0, 0, 0, 8'h59, 4'h0);
        chk("s4b_abort", 32'(abort_cnt), 32'd2);
        chk("s4b_drv", 32'(drv), 32'h0);
        chk("s4b_cap", 32'(cap_out), 32'h0);

        // Reset mid-scan on client 3
        cyc(1, 1, 0, 0, 0, 8'h59, 4'h0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0, 8'h59, 4'h0);
        cyc(0, 0, 1, 1, 0, 8'h59, 4'h0);
        chk("s5_all", 32'({grant, cap_out, sh_out, upd_out, drv}), 32'h0);
        chk("s5_abort", 32'(abort_cnt), 32'h0);
        chk("s5_len", 32'(scan_len), 32'h0);

        // Abort counter saturation
        for (int i = 0; i < 260; i++) begin
            cyc(1, 1, 0, 0, 0, 8'h57, 4'h0);
            cyc(1, 0, 0, 0, 0, 8'h56, 4'h0);
        end
        chk("abort_sat", 32'(abort_cnt), 32'hFF);

        // Long scan saturates SCAN_LEN
        cyc(0, 0, 0, 0, 0, 8'h00, 4'h0);
        cyc(1, 1, 0, 0, 0, 8'h56, 4'h0);
        for (int i = 0; i < 70000; i++) cyc(1, 0, 1, 0, 1'($urandom), 8'h56, 4'h0);
        cyc(1, 0, 0, 1, 0, 8'h56, 4'h0);
        chk("s6_len", 32'(scan_len), 32'hFFFF);
        cyc(1, 0, 0, 0, 0, 8'h56, 4'h0);

        // Randomized traffic against the model
        cur_ir = 8'h57;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) cur_ir = ir_pool[$urandom_range(0, 5)];
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0),
                1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom),
                cur_ir, 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ujtag_chain_arb.md
UJTAG_CHAIN_ARB -- requirements
Module: ujtag_chain_arb

Interface
REQ-001 SHALL have parameter IR_CODE_0, default 8'h56, user IR code selecting client 0.
REQ-002 SHALL have parameter IR_CODE_1, default 8'h57, user IR code selecting client 1.
REQ-003 SHALL have parameter IR_CODE_2, default 8'h58, user IR code selecting client 2.
REQ-004 SHALL have parameter IR_CODE_3, default 8'h59, user IR code selecting client 3.
REQ-005 SHALL have ports:
- UDRCK  in  1  sole clock; UJTAG data-register clock, rising edge.
- URSTB  in  1  reset; synchronous, active-low.
- UIREG_IN  in  8  current UJTAG instruction.
- UDRCAP_IN / UDRSH_IN / UDRUPD_IN  in  1 each  capture / shift / update strobes.
- UTDI_IN  in  1  serial data from UJTAG.
- UTDO_IN  in  4  serial data from clients 0..3.
- UDRCAP_OUT / UDRSH_OUT / UDRUPD_OUT  out  4 each  per-client gated strobes.
- UTDO_OUT  out  1  serial data to UJTAG.
- UTDODRV_OUT  out  1  high while this block owns UTDO.
- GRANT  out  4  one-hot owner of the current scan.
- SCAN_LEN  out  16  bit count of the last completed scan.
- ABORT_CNT  out  8  count of aborted scans.

Function
REQ-006 SHALL implement the FSM IDLE, CAPTURE, SHIFT, UPDATE, with all strobes sampled on rising UDRCK.
REQ-007 IDLE->CAPTURE SHALL occur when UDRCAP_IN=1 and UIREG_IN matches any IR_CODE_n.
- The FSM SHALL latch the match into GRANT and latch UIREG_IN into ir_q.
- If several codes match, the lowest index SHALL win.
REQ-008 UDRCAP_IN=1 with no match SHALL leave the FSM in IDLE with GRANT=0.
REQ-009 CAPTURE->SHIFT SHALL occur on UDRSH_IN=1; CAPTURE->UPDATE SHALL occur on UDRUPD_IN=1 (zero-length scan).
REQ-010 In SHIFT, each cycle with UDRSH_IN=1 SHALL increment the shift counter, saturating at 16'hFFFF.
REQ-011 SHIFT->UPDATE SHALL occur on UDRUPD_IN=1.
- SCAN_LEN SHALL load the shift counter in that same cycle.
- The shift counter SHALL then clear.
REQ-012 UPDATE->IDLE SHALL occur unconditionally after one cycle, and GRANT SHALL clear on entry to IDLE.
REQ-013 Per-client strobe outputs SHALL be registered, one cycle of latency.
- UDRCAP_OUT[n] = registered (UDRCAP_IN & entering CAPTURE & selecting n).
- UDRSH_OUT[n] and UDRUPD_OUT[n] = registered (input strobe & GRANT[n]).
- Non-granted clients SHALL see all strobes at 0.
REQ-014 UTDO_OUT SHALL be the combinational output of a mux:
- UTDO_IN[n] for the granted n;
- otherwise a 1-bit bypass register that captures 0 on UDRCAP_IN and shifts UTDI_IN when UDRSH_IN=1.
REQ-015 UTDODRV_OUT SHALL be 1 in CAPTURE, SHIFT and UPDATE, and 0 in IDLE.
REQ-016 If UIREG_IN differs from ir_q while not in IDLE, the scan SHALL abort:
- FSM to IDLE next cycle;
- GRANT cleared;
- no UDRUPD_OUT pulse;
- SCAN_LEN unchanged;
- ABORT_CNT incremented, saturating at 8'hFF.
REQ-017 If UDRCAP_IN=1 arrives in SHIFT, it SHALL be treated as an abort (REQ-016 rules). It SHALL NOT start a new scan in the same cycle.
REQ-018 Simultaneous UDRSH_IN and UDRUPD_IN in SHIFT SHALL count the shift bit before loading SCAN_LEN.

Reset
REQ-019 When URSTB=0 at a rising UDRCK, the block SHALL reset:
- FSM to IDLE;
- GRANT, all strobe outputs, the shift counter, SCAN_LEN, ABORT_CNT, the bypass register, ir_q and UTDODRV_OUT to 0.
REQ-020 Reset asserted mid-scan SHALL drop the grant without emitting UDRUPD_OUT, and SHALL NOT increment ABORT_CNT.

Structure
REQ-021 A shared package SHALL hold:
- the FSM state encoding;
- the client count constant (4);
- the SCAN_LEN and ABORT_CNT widths.
REQ-022 A single sub-module, ujtag_arb_bypass (bypass register), is natural; all other logic SHALL be flat.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- UIREG=8'h57, capture, 12 shifts, update -> GRANT=4'b0010 throughout; UDRSH_OUT[1] pulses 12 times; UDRUPD_OUT[1] pulses once; SCAN_LEN=12.
- UIREG=8'h20 (no match), 5 shifts of pattern 10110 -> UTDO_OUT is a 0 then 1011 (one-bit bypass delay); GRANT=0; UTDODRV_OUT=0.
- IR_CODE_0=IR_CODE_2=8'h56 overridden, UIREG=8'h56 -> GRANT=4'b0001.
- UIREG changes 8'h58->8'h59 after 3 shifts -> ABORT_CNT=1; no UDRUPD_OUT; SCAN_LEN unchanged.
- URSTB=0 after 4 shifts on client 3 -> all outputs 0 next cycle; ABORT_CNT=0.
- Scan of 70000 shifts -> SCAN_LEN=16'hFFFF.
